// File: rtl/mem_stage.sv
// RV32I memory-access stage: byte-serial loads/stores on an 8-bit bus, load extension, registered write-back.
// Optional define MISALIGN_TRAP_EN: misaligned halfword/word accesses pulse misalign instead of using the bus.
module mem_stage #(
    parameter int ADDR_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_is_load,
    input  logic              ex_is_store,
    input  logic [2:0]        ex_funct3,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [31:0]       ex_sdata,
    input  logic              ex_wd,
    input  logic [REG_AW-1:0] ex_wreg,
    input  logic [31:0]       ex_wdata,
    output logic              stall_req,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ready,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_waddr,
    output logic [31:0]       wb_wdata,
    output logic              misalign
);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [1:0]          r_idx;
    logic                r_is_store;
    logic [2:0]          r_funct3;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_sdata;
    logic                r_wd;
    logic [REG_AW-1:0]   r_wreg;
    logic [31:0]         r_ldata;

    logic                r_wb_we;
    logic [REG_AW-1:0]   r_wb_waddr;
    logic [31:0]         r_wb_wdata;

    logic                w_is_mem;
    logic                w_misaligned;
    logic                w_accept;
    logic [1:0]          w_last_idx;
    logic                w_last;
    logic                w_done;
    logic                w_sext;
    logic [31:0]         w_ldata_merged;
    logic [31:0]         w_load_ext;

    assign w_is_mem = ex_is_load | ex_is_store;

`ifdef MISALIGN_TRAP_EN
    assign w_misaligned = ((ex_funct3[1:0] == 2'b01) & ex_addr[0])
                        | (ex_funct3[1] & (ex_addr[1:0] != 2'b00));
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_accept = (r_state == S_IDLE) & ex_valid & w_is_mem & ~w_misaligned;

    // funct3[1:0]: 00 byte, 01 halfword, 1x word
    always_comb begin
        case (r_funct3[1:0])
            2'b00:   w_last_idx = 2'd0;
            2'b01:   w_last_idx = 2'd1;
            default: w_last_idx = 2'd3;
        endcase
    end

    assign w_last = (r_idx == w_last_idx);
    assign w_done = (r_state == S_BUSY) & mem_ready & w_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        stall_req   = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (r_state)
            S_IDLE: begin
                stall_req = w_accept;
                if (w_accept) begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                mem_req   = 1'b1;
                mem_we    = r_is_store;
                mem_addr  = r_addr + {{(ADDR_W-2){1'b0}}, r_idx};
                mem_wdata = r_sdata[8*r_idx +: 8];
                stall_req = ~w_done;
                if (w_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Little-endian: the byte arriving now lands in lane idx.
    always_comb begin
        w_ldata_merged = r_ldata;
        w_ldata_merged[8*r_idx +: 8] = mem_rdata;
    end

    assign w_sext = ~r_funct3[2];

    always_comb begin
        case (r_funct3[1:0])
            2'b00:   w_load_ext = {{24{w_sext & w_ldata_merged[7]}}, w_ldata_merged[7:0]};
            2'b01:   w_load_ext = {{16{w_sext & w_ldata_merged[15]}}, w_ldata_merged[15:0]};
            default: w_load_ext = w_ldata_merged;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= '0;
            r_is_store <= 1'b0;
            r_funct3   <= '0;
            r_addr     <= '0;
            r_sdata    <= '0;
            r_wd       <= 1'b0;
            r_wreg     <= '0;
            r_ldata    <= '0;
            r_wb_we    <= 1'b0;
            r_wb_waddr <= '0;
            r_wb_wdata <= '0;
        end else begin
            r_wb_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_idx      <= '0;
                        r_is_store <= ex_is_store;
                        r_funct3   <= ex_funct3;
                        r_addr     <= ex_addr;
                        r_sdata    <= ex_sdata;
                        r_wd       <= ex_wd;
                        r_wreg     <= ex_wreg;
                        r_ldata    <= '0;
                    end else if (ex_valid & ~w_is_mem) begin
                        r_wb_we    <= ex_wd;
                        r_wb_waddr <= ex_wreg;
                        r_wb_wdata <= ex_wdata;
                    end
                end
                S_BUSY: begin
                    if (mem_ready) begin
                        r_ldata <= w_ldata_merged;
                        if (w_last) begin
                            r_idx      <= '0;
                            r_wb_we    <= ~r_is_store & r_wd;
                            r_wb_waddr <= r_wreg;
                            r_wb_wdata <= w_load_ext;
                        end else begin
                            r_idx <= r_idx + 2'd1;
                        end
                    end
                end
                default: r_idx <= '0;
            endcase
        end
    end

    assign wb_we    = r_wb_we;
    assign wb_waddr = r_wb_waddr;
    assign wb_wdata = r_wb_wdata;

`ifdef MISALIGN_TRAP_EN
    logic r_misalign;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= (r_state == S_IDLE) & ex_valid & w_is_mem & w_misaligned;
        end
    end

    assign misalign = r_misalign;
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed instructions push expected bus beats and write-backs,
// a monitor pops and compares them as the DUT presents them.
module tb_mem_stage;

    localparam int ADDR_W = 32;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              ex_valid;
    logic              ex_is_load;
    logic              ex_is_store;
    logic [2:0]        ex_funct3;
    logic [ADDR_W-1:0] ex_addr;
    logic [31:0]       ex_sdata;
    logic              ex_wd;
    logic [REG_AW-1:0] ex_wreg;
    logic [31:0]       ex_wdata;
    logic              stall_req;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_ready;
    logic              wb_we;
    logic [REG_AW-1:0] wb_waddr;
    logic [31:0]       wb_wdata;
    logic              misalign;

    always #5 clk = ~clk;

    mem_stage #(.ADDR_W(ADDR_W), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_sdata(ex_sdata),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .stall_req(stall_req), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .wb_we(wb_we), .wb_waddr(wb_waddr),
        .wb_wdata(wb_wdata), .misalign(misalign)
    );

    typedef struct {
        logic [REG_AW-1:0] waddr;
        logic [31:0]       wdata;
    } wb_exp_t;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        wdata;
    } bus_exp_t;

    wb_exp_t    exp_wb[$];
    bus_exp_t   exp_bus[$];
    int         exp_mis[$];
    logic [7:0] rd_q[$];
    int         ready_delay = 0;
    int         wait_cnt    = 0;
    int         n_checks    = 0;
    int         n_errors    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void push_wb(input logic [REG_AW-1:0] a, input logic [31:0] d);
        wb_exp_t e;
        e.waddr = a;
        e.wdata = d;
        exp_wb.push_back(e);
    endfunction

    function automatic void push_bus(input logic we, input logic [ADDR_W-1:0] a, input logic [7:0] d);
        bus_exp_t e;
        e.we    = we;
        e.addr  = a;
        e.wdata = d;
        exp_bus.push_back(e);
    endfunction

    // Bus responder: ready_delay wait cycles, then one ready cycle per byte.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                if (wait_cnt >= ready_delay) begin
                    mem_ready = 1'b1;
                    if (rd_q.size() > 0) mem_rdata = rd_q.pop_front();
                    else mem_rdata = 8'hEE;
                    wait_cnt = 0;
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = 8'h00;
                    wait_cnt++;
                end
            end else begin
                mem_ready = 1'b0;
                wait_cnt  = 0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a write-back, bus beat or trap pulse.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (wb_we) begin
                    check("wb_expected", 64'(exp_wb.size() != 0), 64'd1);
                    if (exp_wb.size() != 0) begin
                        wb_exp_t e;
                        e = exp_wb.pop_front();
                        check("wb_waddr", 64'(wb_waddr), 64'(e.waddr));
                        check("wb_wdata", 64'(wb_wdata), 64'(e.wdata));
                    end
                end
                if (mem_req && mem_ready) begin
                    check("bus_expected", 64'(exp_bus.size() != 0), 64'd1);
                    if (exp_bus.size() != 0) begin
                        bus_exp_t b;
                        b = exp_bus.pop_front();
                        check("bus_we", 64'(mem_we), 64'(b.we));
                        check("bus_addr", 64'(mem_addr), 64'(b.addr));
                        if (b.we) check("bus_wdata", 64'(mem_wdata), 64'(b.wdata));
                    end
                end
                if (misalign) begin
                    check("misalign_expected", 64'(exp_mis.size() != 0), 64'd1);
                    if (exp_mis.size() != 0) void'(exp_mis.pop_front());
                end
            end
        end
    end

    // Presents one instruction and holds it while stall_req is high; counts stalled cycles.
    task automatic issue(input string name, input logic ld, input logic st, input logic [2:0] f3,
                         input logic [ADDR_W-1:0] addr, input logic [31:0] sdata, input logic wd,
                         input logic [REG_AW-1:0] wreg, input logic [31:0] wdata, input int exp_stall);
        int n;
        @(negedge clk);
        ex_valid    = 1'b1;
        ex_is_load  = ld;
        ex_is_store = st;
        ex_funct3   = f3;
        ex_addr     = addr;
        ex_sdata    = sdata;
        ex_wd       = wd;
        ex_wreg     = wreg;
        ex_wdata    = wdata;
        n = 0;
        #2;
        while (stall_req && n < 200) begin
            n++;
            @(negedge clk);
            #2;
        end
        check({name, "_stall"}, 64'(n), 64'(exp_stall));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        ex_valid    = 1'b0;
        ex_is_load  = 1'b0;
        ex_is_store = 1'b0;
        ex_funct3   = 3'b000;
        ex_addr     = '0;
        ex_sdata    = '0;
        ex_wd       = 1'b0;
        ex_wreg     = '0;
        ex_wdata    = '0;
        repeat (3) @(negedge clk);
        #2;
        check("rst_mem_req",   64'(mem_req),   64'd0);
        check("rst_stall_req", 64'(stall_req), 64'd0);
        check("rst_mem_we",    64'(mem_we),    64'd0);
        check("rst_mem_addr",  64'(mem_addr),  64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_wb_we",     64'(wb_we),     64'd0);
        check("rst_wb_waddr",  64'(wb_waddr),  64'd0);
        check("rst_wb_wdata",  64'(wb_wdata),  64'd0);
        check("rst_misalign",  64'(misalign),  64'd0);
        rst = 1'b0;

        push_wb(5'd5, 32'h0000_1234);
        issue("alu", 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 5'd5, 32'h0000_1234, 0);
        issue("alu_nowd", 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 5'd7, 32'hDEAD_BEEF, 0);

        ready_delay = 0;
        for (int i = 0; i < 4; i++) push_bus(1'b0, 32'h100 + i, 8'h00);
        rd_q = '{8'h78, 8'h56, 8'h34, 8'h12};
        push_wb(5'd10, 32'h1234_5678);
        issue("lw", 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1'b1, 5'd10, 32'h0, 4);

        push_wb(5'd6, 32'h0000_CAFE);
        issue("alu_b2b", 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 5'd6, 32'h0000_CAFE, 0);

        push_bus(1'b0, 32'h7, 8'h00);
        rd_q = '{8'h80};
        push_wb(5'd11, 32'hFFFF_FF80);
        issue("lb", 1'b1, 1'b0, 3'b000, 32'h7, 32'h0, 1'b1, 5'd11, 32'h0, 1);

        push_bus(1'b0, 32'h7, 8'h00);
        rd_q = '{8'h80};
        push_wb(5'd12, 32'h0000_0080);
        issue("lbu", 1'b1, 1'b0, 3'b100, 32'h7, 32'h0, 1'b1, 5'd12, 32'h0, 1);

        push_bus(1'b0, 32'h40, 8'h00);
        push_bus(1'b0, 32'h41, 8'h00);
        rd_q = '{8'h01, 8'h80};
        push_wb(5'd13, 32'h0000_8001);
        issue("lhu", 1'b1, 1'b0, 3'b101, 32'h40, 32'h0, 1'b1, 5'd13, 32'h0, 2);

        push_bus(1'b0, 32'h42, 8'h00);
        push_bus(1'b0, 32'h43, 8'h00);
        rd_q = '{8'h01, 8'h80};
        push_wb(5'd14, 32'hFFFF_8001);
        issue("lh", 1'b1, 1'b0, 3'b001, 32'h42, 32'h0, 1'b1, 5'd14, 32'h0, 2);

        ready_delay = 3;
        push_bus(1'b1, 32'h20, 8'hDD);
        push_bus(1'b1, 32'h21, 8'hCC);
        issue("sh_slow", 1'b0, 1'b1, 3'b001, 32'h20, 32'hAABB_CCDD, 1'b1, 5'd15, 32'h0, 8);
        ready_delay = 0;

        push_bus(1'b1, 32'h30, 8'h44);
        push_bus(1'b1, 32'h31, 8'h33);
        push_bus(1'b1, 32'h32, 8'h22);
        push_bus(1'b1, 32'h33, 8'h11);
        issue("sw", 1'b0, 1'b1, 3'b010, 32'h30, 32'h1122_3344, 1'b0, 5'd0, 32'h0, 4);

        push_bus(1'b1, 32'h3, 8'h5A);
        issue("sb", 1'b0, 1'b1, 3'b000, 32'h3, 32'h0000_005A, 1'b0, 5'd0, 32'h0, 1);

        push_bus(1'b0, 32'h5, 8'h00);
        rd_q = '{8'h7F};
        push_wb(5'd0, 32'h0000_007F);
        issue("lbu_x0", 1'b1, 1'b0, 3'b100, 32'h5, 32'h0, 1'b1, 5'd0, 32'h0, 1);

`ifdef MISALIGN_TRAP_EN
        exp_mis.push_back(1);
        issue("lw_mis", 1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 1'b1, 5'd16, 32'h0, 0);
        exp_mis.push_back(1);
        issue("lhu_wrap", 1'b1, 1'b0, 3'b101, 32'hFFFF_FFFF, 32'h0, 1'b1, 5'd17, 32'h0, 0);
`else
        for (int i = 0; i < 4; i++) push_bus(1'b0, 32'h102 + i, 8'h00);
        rd_q = '{8'h44, 8'h33, 8'h22, 8'h11};
        push_wb(5'd16, 32'h1122_3344);
        issue("lw_mis", 1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 1'b1, 5'd16, 32'h0, 4);
        push_bus(1'b0, 32'hFFFF_FFFF, 8'h00);
        push_bus(1'b0, 32'h0000_0000, 8'h00);
        rd_q = '{8'h34, 8'h12};
        push_wb(5'd17, 32'h0000_1234);
        issue("lhu_wrap", 1'b1, 1'b0, 3'b101, 32'hFFFF_FFFF, 32'h0, 1'b1, 5'd17, 32'h0, 2);
`endif

        // Reset mid-transfer: two beats complete, reset lands as the third completes.
        push_bus(1'b0, 32'h200, 8'h00);
        push_bus(1'b0, 32'h201, 8'h00);
        rd_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        @(negedge clk);
        ex_valid    = 1'b1;
        ex_is_load  = 1'b1;
        ex_is_store = 1'b0;
        ex_funct3   = 3'b010;
        ex_addr     = 32'h200;
        ex_wd       = 1'b1;
        ex_wreg     = 5'd18;
        @(negedge clk);
        ex_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #2;
        check("rstbusy_mem_req",   64'(mem_req),   64'd0);
        check("rstbusy_stall_req", 64'(stall_req), 64'd0);
        check("rstbusy_wb_we",     64'(wb_we),     64'd0);
        rst = 1'b0;
        rd_q.delete();

        for (int i = 0; i < 4; i++) push_bus(1'b0, 32'h300 + i, 8'h00);
        rd_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        push_wb(5'd19, 32'h0403_0201);
        issue("lw_after_rst", 1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 1'b1, 5'd19, 32'h0, 4);

        @(negedge clk);
        ex_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("wb_queue_drained",  64'(exp_wb.size()),  64'd0);
        check("bus_queue_drained", 64'(exp_bus.size()), 64'd0);
        check("mis_queue_drained", 64'(exp_mis.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
